ag_temp_in: RTL and testbench

Address generator for the systolic array's temporary input buffer. A start request launches one full sweep over a NUM_ROWS x NUM_COLS tile. The block emits one buffer address per sys_clk cycle, then pulses done. Address format is {row, col}, each field FEATURE_BITS wide, feeding the temp-buffer read port.

---
 rtl/ag_temp_in.sv | 95 +++++++++
 tb/tb_ag_temp_in.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ag_temp_in.sv
// Address generator for the systolic array temp-input buffer: one {row, col} address per cycle over a tile.
// Optional macro AG_TEMP_IN_TRANSPOSE_EN selects column-major (transposed) sweep order.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | presenting one tile address per cycle
// DONE  | one-cycle done pulse, then back to IDLE
module ag_temp_in #(
  parameter int FEATURE_BITS = 4,
  parameter int NUM_ROWS     = 2**FEATURE_BITS,
  parameter int NUM_COLS     = 2**FEATURE_BITS
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  output logic                      valid,
  output logic [2*FEATURE_BITS-1:0] address
);

  localparam logic [FEATURE_BITS-1:0] ROW_LAST = FEATURE_BITS'(NUM_ROWS - 1);
  localparam logic [FEATURE_BITS-1:0] COL_LAST = FEATURE_BITS'(NUM_COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_next;
  logic [FEATURE_BITS-1:0] row, row_next;
  logic [FEATURE_BITS-1:0] col, col_next;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      row   <= row_next;
      col   <= col_next;
      valid <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    case (state)
      IDLE: begin
        row_next = '0;
        col_next = '0;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (row == ROW_LAST && col == COL_LAST) begin
          state_next = DONE;
          row_next   = '0;
          col_next   = '0;
        end else begin
`ifdef AG_TEMP_IN_TRANSPOSE_EN
          if (row == ROW_LAST) begin
            row_next = '0;
            col_next = col + 1'b1;
          end else begin
            row_next = row + 1'b1;
          end
`else
          if (col == COL_LAST) begin
            col_next = '0;
            row_next = row + 1'b1;
          end else begin
            col_next = col + 1'b1;
          end
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
        row_next   = '0;
        col_next   = '0;
      end
      default: begin
        state_next = IDLE;
        row_next   = '0;
        col_next   = '0;
      end
    endcase
  end

  // Counters are cleared outside RUN, so the address reads 0 in IDLE and DONE.
  assign address = {row, col};

endmodule

// File: tb/tb_ag_temp_in.sv
// Directed self-checking bench for ag_temp_in: default 16x16 tile plus a 3x2 tile instance.
module tb_ag_temp_in;

  logic       sys_clk;
  logic       reset;
  logic       start;
  logic       start_s;
  logic       done, valid;
  logic [7:0] address;
  logic       done_s, valid_s;
  logic [7:0] address_s;

  int checks = 0;
  int errors = 0;

  ag_temp_in dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .done    (done),
    .valid   (valid),
    .address (address)
  );

  ag_temp_in #(.FEATURE_BITS(4), .NUM_ROWS(3), .NUM_COLS(2)) dut_s (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start_s),
    .done    (done_s),
    .valid   (valid_s),
    .address (address_s)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected address for sweep index i on the 16x16 tile.
  function automatic logic [7:0] exp_addr(input int i);
    logic [7:0] b;
    b = i[7:0];
`ifdef AG_TEMP_IN_TRANSPOSE_EN
    return {b[3:0], b[7:4]};
`else
    return b;
`endif
  endfunction

  function automatic logic [31:0] obs();
    return 32'({done, valid, address});
  endfunction

  // Caller raises start at a negedge; start is dropped after the first address.
  task automatic run_sweep(input int pulse_idx);
    for (int i = 0; i < 256; i++) begin
      @(negedge sys_clk);
      chk("sweep", obs(), 32'({1'b0, 1'b1, exp_addr(i)}));
      if (i == 0) start = 1'b0;
      if (i == pulse_idx) start = 1'b1;
      if (i == pulse_idx + 1) start = 1'b0;
    end
    @(negedge sys_clk);
    chk("done_pulse", obs(), 32'({1'b1, 1'b0, 8'h00}));
    @(negedge sys_clk);
    chk("back_idle", obs(), 32'h0);
    @(negedge sys_clk);
    chk("stay_idle", obs(), 32'h0);
  endtask

  logic [7:0] small_tab [6];
  int cnt;
  logic found;

  initial begin
`ifdef AG_TEMP_IN_TRANSPOSE_EN
    small_tab = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h21};
`else
    small_tab = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21};
`endif
    reset   = 1'b1;
    start   = 1'bx;
    start_s = 1'b0;

    // Reset behaviour and idle with start low
    repeat (2) begin
      @(negedge sys_clk);
      chk("reset_out", obs(), 32'h0);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      chk("idle_nostart", obs(), 32'h0);
    end

    // Full default sweep
    start = 1'b1;
    run_sweep(-1);

    // Start re-pulsed mid-sweep at index 0x42 is ignored
    start = 1'b1;
    run_sweep(8'h42);

    // Asynchronous reset mid-sweep, then restart from 0
    start = 1'b1;
    for (int i = 0; i <= 8'h37; i++) begin
      @(negedge sys_clk);
      chk("pre_reset", obs(), 32'({1'b0, 1'b1, exp_addr(i)}));
      if (i == 0) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1 chk("async_reset", obs(), 32'h0);
    @(negedge sys_clk);
    chk("held_reset", obs(), 32'h0);
    reset = 1'b0;
    start = 1'b1;
    run_sweep(-1);

    // 3x2 tile
    start_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      chk("small_sweep", 32'({done_s, valid_s, address_s}), 32'({1'b0, 1'b1, small_tab[i]}));
      if (i == 0) start_s = 1'b0;
    end
    @(negedge sys_clk);
    chk("small_done", 32'({done_s, valid_s, address_s}), 32'({1'b1, 1'b0, 8'h00}));
    @(negedge sys_clk);
    chk("small_idle", 32'({done_s, valid_s, address_s}), 32'h0);

    // Continuous start: back-to-back sweeps with a 258-cycle done period
    start = 1'b1;
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < 400) begin
      @(negedge sys_clk);
      cnt++;
      if (done) found = 1'b1;
    end
    chk("first_done_seen", 32'(found), 32'h1);
    repeat (2) begin
      cnt = 0;
      found = 1'b0;
      while (!found && cnt < 400) begin
        @(negedge sys_clk);
        cnt++;
        chk("excl", 32'(done & valid), 32'h0);
        if (cnt == 1) chk("gap_idle", obs(), 32'h0);
        if (cnt == 2) chk("restart_addr", obs(), 32'({1'b0, 1'b1, 8'h00}));
        if (done) found = 1'b1;
      end
      chk("done_period", 32'(cnt), 32'd258);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
